stream_accumulator: RTL and testbench
=====================================

STREAM_ACCUMULATOR -- requirements
Module: stream_accumulator

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning input element width.
REQ-002 SHALL have parameter ACC_W, default 32, meaning accumulator/result width (ACC_W >= DATA_W).
REQ-003 SHALL have parameter LEN_W, default 16, meaning frame-length field width.
REQ-004 SHALL have parameter SATURATE, default 0, meaning 0 = wrap-around arithmetic and 1 = unsigned saturation.
REQ-005 SHALL have port clk, input, 1, meaning the single clock; all state on its rising edge.
REQ-006 SHALL have port reset, input, 1, meaning asynchronous active-low reset (0 = reset asserted).
REQ-007 SHALL have port io_cfg_len, input, LEN_W, meaning elements per frame, sampled at frame start.
REQ-008 SHALL have port io_streamInput_valid, input, 1, meaning input element offered.
REQ-009 SHALL have port io_streamInput_ready, output, 1, meaning input element accepted this cycle if valid.
REQ-010 SHALL have port io_streamInput_bits, input, DATA_W, meaning unsigned input element.
REQ-011 SHALL have port io_streamOutput_valid, output, 1, meaning frame result offered.
REQ-012 SHALL have port io_streamOutput_ready, input, 1, meaning consumer accepts result.
REQ-013 SHALL have port io_streamOutput_bits, output, ACC_W, meaning frame sum.
REQ-014 SHALL have port io_streamOutput_overflow, output, 1, meaning the frame overflowed (wrapped or clipped).
REQ-015 SHALL have port io_out, output, ACC_W, meaning live running sum of the current frame.
REQ-016 SHALL have port io_frameCount, output, 32, meaning frames emitted since reset, wrapping at 2^32.

Function
REQ-017 SHALL define transfers: input fire = in_valid & in_ready; output fire = out_valid & out_ready.
REQ-018 SHALL implement two states: ACCUM and EMIT.
REQ-019 In ACCUM: in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-020 On the first input fire of a frame (element index 0): the block SHALL latch io_cfg_len, treating 0 as 1, and changes to io_cfg_len mid-frame SHALL have no effect.
REQ-021 On each input fire: acc SHALL become acc + zero-extended bits; index 0 SHALL load bits, ignoring the prior acc.
REQ-022 Arithmetic: the sum SHALL be computed at ACC_W+1 bits; on carry, SATURATE=0 SHALL keep the low ACC_W bits and SATURATE=1 SHALL clamp to 2^ACC_W-1; either case SHALL set the frame's sticky overflow flag.
REQ-023 On the input fire of the element that completes the latched length: the block SHALL enter EMIT next cycle, with out_valid=1 and bits/overflow holding the final sum and flag (latency 1 cycle from last element).
REQ-024 In EMIT: out_bits/out_overflow SHALL remain stable until output fire, and in_ready SHALL equal io_streamOutput_ready.
REQ-025 On output fire with no input fire in the same cycle: the block SHALL return to ACCUM, clear acc, overflow and the index, and increment io_frameCount.
REQ-026 On output fire and input fire in the same cycle: the accepted element SHALL become index 0 of the next frame (length latched now); if that length is 1, the block SHALL stay in EMIT with the new sum next cycle; otherwise it SHALL go to ACCUM with the index at 1. Zero bubbles SHALL occur between frames.
REQ-027 io_out SHALL show the registered acc (0 after frame clear), and SHALL equal out_bits while in EMIT.
REQ-028 The element index SHALL be LEN_W bits and SHALL never wrap within a frame, since the length is at most 2^LEN_W-1.

Reset
REQ-029 While reset=0, the block SHALL be asynchronously in state ACCUM, with acc=0, index=0, latched len=1, overflow=0 and io_frameCount=0.
REQ-030 Reset values SHALL be: io_streamInput_ready=1, io_streamOutput_valid=0, io_streamOutput_bits=0, io_streamOutput_overflow=0, io_out=0, io_frameCount=0.
REQ-031 Reset mid-frame or mid-EMIT SHALL discard the partial or pending result; no output fire SHALL follow from it.
REQ-032 Reset deassertion SHALL be synchronised externally; the block SHALL accept input on the first clock edge after deassertion.

Structure
REQ-033 A shared package stream_acc_pkg SHALL hold the state enum (ACCUM, EMIT) and the default parameter constants.
REQ-034 One sub-module, sat_adder (params ACC_W, SATURATE; outputs sum and ovf), SHALL implement REQ-022 combinationally.
REQ-035 All other logic SHALL live in stream_accumulator; no memories.

Verification
REQ-036 len=4, inputs 1,2,3,4, out_ready=1 -> out_valid one cycle after 4th fire with bits=10, overflow=0, frameCount=1.
REQ-037 ACC_W=DATA_W=8, SATURATE=0, len=2, inputs 200,100 -> bits=44, overflow=1; same with SATURATE=1 -> bits=255, overflow=1.
REQ-038 len=2, inputs 5,6, out_ready low 3 cycles -> bits=11 held stable, in_ready=0 for 3 cycles, one output fire, frameCount=1.
REQ-039 len=1, continuous valid inputs 7,8,9, out_ready=1 -> results 7,8,9 on consecutive cycles, in_ready always 1.
REQ-040 len=3, two elements accepted, then reset=0 one cycle, then len=0 with input 42 -> single result 42, overflow=0, frameCount=1.
REQ-041 len changed from 4 to 2 after first element of 10,20,30,40 -> result 100 (old length honoured).

Source files
------------

// File: rtl/stream_acc_pkg.sv
// Shared types and default parameters for the stream accumulator.
package stream_acc_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_ACC_W    = 32;
    localparam int unsigned DEF_LEN_W    = 16;
    localparam bit          DEF_SATURATE = 1'b0;
    localparam int unsigned FRAME_CNT_W  = 32;

    typedef enum logic {
        ACCUM = 1'b0,
        EMIT  = 1'b1
    } state_e;

endpackage

// File: rtl/sat_adder.sv
// Unsigned ACC_W adder with carry detection; wraps or clamps on carry.
module sat_adder
    import stream_acc_pkg::*;
#(
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter bit          SATURATE = DEF_SATURATE
) (
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full_sum;

    always_comb begin
        full_sum = {1'b0, a} + {1'b0, b};
        ovf      = full_sum[ACC_W];
        sum      = full_sum[ACC_W-1:0];
        if (SATURATE && ovf) begin
            sum = '1;
        end
    end

endmodule

// File: rtl/stream_accumulator.sv
// Sums fixed-length frames of an input stream and offers each frame sum downstream.
module stream_accumulator
    import stream_acc_pkg::*;
#(
    parameter int unsigned DATA_W   = DEF_DATA_W,
    parameter int unsigned ACC_W    = DEF_ACC_W,
    parameter int unsigned LEN_W    = DEF_LEN_W,
    parameter bit          SATURATE = DEF_SATURATE
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [LEN_W-1:0]       io_cfg_len,
    input  logic                   io_streamInput_valid,
    output logic                   io_streamInput_ready,
    input  logic [DATA_W-1:0]      io_streamInput_bits,
    output logic                   io_streamOutput_valid,
    input  logic                   io_streamOutput_ready,
    output logic [ACC_W-1:0]       io_streamOutput_bits,
    output logic                   io_streamOutput_overflow,
    output logic [ACC_W-1:0]       io_out,
    output logic [FRAME_CNT_W-1:0] io_frameCount
);

    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic [LEN_W-1:0]       idx_q, idx_d;
    logic [LEN_W-1:0]       len_q, len_d;
    logic [FRAME_CNT_W-1:0] frames_q, frames_d;

    logic             in_fire;
    logic             out_fire;
    logic             first_elem;
    logic [LEN_W-1:0] cfg_len;
    logic [LEN_W-1:0] eff_len;
    logic [LEN_W-1:0] idx_next;
    logic [ACC_W-1:0] add_a;
    logic [ACC_W-1:0] add_b;
    logic [ACC_W-1:0] add_sum;
    logic             add_ovf;

    // In EMIT a new element may only enter when the pending result leaves
    assign io_streamInput_ready = (state_q == ACCUM) ? 1'b1 : io_streamOutput_ready;
    assign io_streamOutput_valid = (state_q == EMIT);
    assign in_fire  = io_streamInput_valid & io_streamInput_ready;
    assign out_fire = io_streamOutput_valid & io_streamOutput_ready;

    // Index is held at 0 in EMIT, so any element accepted there opens a new frame
    assign first_elem = (idx_q == '0);
    assign cfg_len    = (io_cfg_len == '0) ? LEN_W'(1) : io_cfg_len;
    assign eff_len    = first_elem ? cfg_len : len_q;
    assign idx_next   = idx_q + LEN_W'(1);
    assign add_a      = first_elem ? '0 : acc_q;
    assign add_b      = ACC_W'(io_streamInput_bits);

    sat_adder #(
        .ACC_W    (ACC_W),
        .SATURATE (SATURATE)
    ) u_sat_adder (
        .a   (add_a),
        .b   (add_b),
        .sum (add_sum),
        .ovf (add_ovf)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        idx_d    = idx_q;
        len_d    = len_q;
        frames_d = frames_q;

        if (out_fire) begin
            frames_d = frames_q + FRAME_CNT_W'(1);
            state_d  = ACCUM;
            acc_d    = '0;
            ovf_d    = 1'b0;
            idx_d    = '0;
        end

        if (in_fire) begin
            acc_d   = add_sum;
            ovf_d   = (~first_elem & ovf_q) | add_ovf;
            len_d   = eff_len;
            state_d = ACCUM;
            idx_d   = idx_next;
            if (idx_next == eff_len) begin
                state_d = EMIT;
                idx_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= ACCUM;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            idx_q    <= '0;
            len_q    <= LEN_W'(1);
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            frames_q <= frames_d;
        end
    end

    assign io_streamOutput_bits     = acc_q;
    assign io_streamOutput_overflow = ovf_q;
    assign io_out                   = acc_q;
    assign io_frameCount            = frames_q;

endmodule

// File: tb/tb_stream_accumulator.sv
// Drives a wrapping and a saturating 8-bit accumulator in lockstep against a frame-level model.
module tb_stream_accumulator;

    logic        clk;
    logic        reset;
    logic [15:0] cfg_len;
    logic        in_valid;
    logic [7:0]  in_bits;
    logic        out_ready;

    logic        w_in_ready, w_out_valid, w_ovf;
    logic [7:0]  w_bits, w_out;
    logic [31:0] w_frames;
    logic        s_in_ready, s_out_valid, s_ovf;
    logic [7:0]  s_bits, s_out;
    logic [31:0] s_frames;

    int checks = 0;
    int errors = 0;

    stream_accumulator #(
        .DATA_W(8), .ACC_W(8), .LEN_W(16), .SATURATE(1'b0)
    ) u_wrap (
        .clk                      (clk),
        .reset                    (reset),
        .io_cfg_len               (cfg_len),
        .io_streamInput_valid     (in_valid),
        .io_streamInput_ready     (w_in_ready),
        .io_streamInput_bits      (in_bits),
        .io_streamOutput_valid    (w_out_valid),
        .io_streamOutput_ready    (out_ready),
        .io_streamOutput_bits     (w_bits),
        .io_streamOutput_overflow (w_ovf),
        .io_out                   (w_out),
        .io_frameCount            (w_frames)
    );

    stream_accumulator #(
        .DATA_W(8), .ACC_W(8), .LEN_W(16), .SATURATE(1'b1)
    ) u_sat (
        .clk                      (clk),
        .reset                    (reset),
        .io_cfg_len               (cfg_len),
        .io_streamInput_valid     (in_valid),
        .io_streamInput_ready     (s_in_ready),
        .io_streamInput_bits      (in_bits),
        .io_streamOutput_valid    (s_out_valid),
        .io_streamOutput_ready    (out_ready),
        .io_streamOutput_bits     (s_bits),
        .io_streamOutput_overflow (s_ovf),
        .io_out                   (s_out),
        .io_frameCount            (s_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level model: elements collected per frame, one pending result at most
    bit m_pending;
    int m_cnt, m_len, m_frames;
    int m_run_w, m_run_s, m_res_w, m_res_s;
    bit m_run_ovf, m_res_ovf;

    always @(posedge clk or negedge reset) begin
        bit ofire, ifire;
        int t;
        if (!reset) begin
            m_pending = 0; m_cnt = 0; m_len = 1; m_frames = 0;
            m_run_w = 0; m_run_s = 0; m_res_w = 0; m_res_s = 0;
            m_run_ovf = 0; m_res_ovf = 0;
        end else begin
            ofire = m_pending && out_ready;
            ifire = in_valid && (!m_pending || out_ready);
            if (ofire) begin
                m_pending = 0;
                m_frames++;
            end
            if (ifire) begin
                if (m_cnt == 0) begin
                    m_len     = (cfg_len == 0) ? 1 : int'(cfg_len);
                    m_run_w   = int'(in_bits);
                    m_run_s   = int'(in_bits);
                    m_run_ovf = 0;
                end else begin
                    t = m_run_w + int'(in_bits);
                    if (t > 255) m_run_ovf = 1;
                    m_run_w = t % 256;
                    t = m_run_s + int'(in_bits);
                    m_run_s = (t > 255) ? 255 : t;
                end
                m_cnt++;
                if (m_cnt == m_len) begin
                    m_pending = 1;
                    m_res_w   = m_run_w;
                    m_res_s   = m_run_s;
                    m_res_ovf = m_run_ovf;
                    m_cnt     = 0;
                end
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        logic exp_rdy;
        int   exp_out_w, exp_out_s;
        exp_rdy   = !m_pending || out_ready;
        exp_out_w = m_pending ? m_res_w : (m_cnt == 0 ? 0 : m_run_w);
        exp_out_s = m_pending ? m_res_s : (m_cnt == 0 ? 0 : m_run_s);
        chk("w_in_ready", 32'(w_in_ready), 32'(exp_rdy));
        chk("s_in_ready", 32'(s_in_ready), 32'(exp_rdy));
        chk("w_out_valid", 32'(w_out_valid), 32'(m_pending));
        chk("s_out_valid", 32'(s_out_valid), 32'(m_pending));
        if (m_pending) begin
            chk("w_out_bits", 32'(w_bits), 32'(m_res_w));
            chk("s_out_bits", 32'(s_bits), 32'(m_res_s));
            chk("w_overflow", 32'(w_ovf), 32'(m_res_ovf));
            chk("s_overflow", 32'(s_ovf), 32'(m_res_ovf));
        end
        chk("w_io_out", 32'(w_out), 32'(exp_out_w));
        chk("s_io_out", 32'(s_out), 32'(exp_out_s));
        chk("w_frame_count", w_frames, 32'(m_frames));
        chk("s_frame_count", s_frames, 32'(m_frames));
    end

    // One clock cycle of stimulus; returns just after the edge
    task automatic drive(input logic v, input logic [7:0] b, input logic [15:0] l, input logic r);
        in_valid  = v;
        in_bits   = b;
        cfg_len   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_bits = '0; cfg_len = 16'd1; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(w_in_ready), 32'd1);
        chk("rst_out_valid", 32'(w_out_valid), 32'd0);
        chk("rst_io_out", 32'(w_out), 32'd0);
        chk("rst_frames", w_frames, 32'd0);
        reset = 1'b1;

        // Basic frame of four
        drive(1, 8'd1, 16'd4, 1); drive(1, 8'd2, 16'd4, 1);
        drive(1, 8'd3, 16'd4, 1); drive(1, 8'd4, 16'd4, 1);
        chk("len4_valid", 32'(w_out_valid), 32'd1);
        chk("len4_sum", 32'(w_bits), 32'd10);
        chk("len4_ovf", 32'(w_ovf), 32'd0);
        drive(0, 8'd0, 16'd4, 1);
        chk("len4_frames", w_frames, 32'd1);

        // Overflow: wrap vs clamp
        drive(1, 8'd200, 16'd2, 1); drive(1, 8'd100, 16'd2, 1);
        chk("wrap_sum", 32'(w_bits), 32'd44);
        chk("wrap_ovf", 32'(w_ovf), 32'd1);
        chk("sat_sum", 32'(s_bits), 32'd255);
        chk("sat_ovf", 32'(s_ovf), 32'd1);
        drive(0, 8'd0, 16'd2, 1);

        // Backpressure holds the result; offered element must wait
        drive(1, 8'd5, 16'd2, 0); drive(1, 8'd6, 16'd2, 0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_in_ready", 32'(w_in_ready), 32'd0);
            chk("stall_sum", 32'(w_bits), 32'd11);
            if (i < 2) drive(1, 8'd99, 16'd2, 0);
        end
        drive(0, 8'd0, 16'd2, 1);
        chk("stall_frames", w_frames, 32'd3);

        // Single-element frames back to back
        drive(1, 8'd7, 16'd1, 1);
        chk("len1_a", 32'(w_bits), 32'd7);
        drive(1, 8'd8, 16'd1, 1);
        chk("len1_b", 32'(w_bits), 32'd8);
        drive(1, 8'd9, 16'd1, 1);
        chk("len1_c", 32'(w_bits), 32'd9);
        chk("len1_valid", 32'(w_out_valid), 32'd1);
        drive(0, 8'd0, 16'd1, 1);
        chk("len1_frames", w_frames, 32'd6);

        // Reset mid-frame discards the partial sum
        drive(1, 8'd1, 16'd3, 1); drive(1, 8'd2, 16'd3, 1);
        reset = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        chk("midrst_valid", 32'(w_out_valid), 32'd0);
        chk("midrst_io_out", 32'(w_out), 32'd0);
        chk("midrst_frames", w_frames, 32'd0);
        chk("midrst_in_ready", 32'(w_in_ready), 32'd1);
        reset = 1'b1;
        drive(1, 8'd42, 16'd0, 1);
        chk("len0_sum", 32'(w_bits), 32'd42);
        chk("len0_ovf", 32'(w_ovf), 32'd0);
        drive(0, 8'd0, 16'd0, 1);
        chk("len0_frames", w_frames, 32'd1);

        // Length change mid-frame is ignored
        drive(1, 8'd10, 16'd4, 1); drive(1, 8'd20, 16'd2, 1);
        chk("lenchg_not_done", 32'(w_out_valid), 32'd0);
        drive(1, 8'd30, 16'd2, 1); drive(1, 8'd40, 16'd2, 1);
        chk("lenchg_sum", 32'(w_bits), 32'd100);
        drive(0, 8'd0, 16'd2, 1);

        // Zero-bubble handoff into a two-element frame
        drive(1, 8'd1, 16'd2, 1); drive(1, 8'd2, 16'd2, 1);
        chk("bubble_a", 32'(w_bits), 32'd3);
        drive(1, 8'd3, 16'd2, 1);
        chk("bubble_accum", 32'(w_out_valid), 32'd0);
        chk("bubble_io_out", 32'(w_out), 32'd3);
        drive(1, 8'd4, 16'd2, 1);
        chk("bubble_b", 32'(w_bits), 32'd7);
        drive(0, 8'd0, 16'd2, 1);
        chk("bubble_frames", w_frames, 32'd4);

        // Overflow stays sticky across later elements
        drive(1, 8'd200, 16'd3, 1); drive(1, 8'd100, 16'd3, 1); drive(1, 8'd10, 16'd3, 1);
        chk("sticky_wrap", 32'(w_bits), 32'd54);
        chk("sticky_sat", 32'(s_bits), 32'd255);
        chk("sticky_ovf", 32'(w_ovf), 32'd1);
        drive(0, 8'd0, 16'd3, 1);
        chk("final_frames", s_frames, 32'd5);
        drive(0, 8'd0, 16'd3, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
